// File: rtl/md5_reverse.sv
// Iterative inverse of the 64-operation MD5 round chain: strips the salts from a
// digest and unwinds one operation per clock back to the pre-round state.

`ifndef SALT_A
`define SALT_A 32'h67452301
`endif
`ifndef SALT_B
`define SALT_B 32'hefcdab89
`endif
`ifndef SALT_C
`define SALT_C 32'h98badcfe
`endif
`ifndef SALT_D
`define SALT_D 32'h10325476
`endif

module md5_reverse (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] message,
    input  logic [127:0] digest,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out,
    output logic         match
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [5:0]     cnt;
    logic [127:0]   st;
    logic [511:0]   msg_q;

    logic [1:0]     rnd;
    logic [3:0]     phase, k;
    logic [4:0]     s;
    logic [31:0]    n0, n1, n2, n3, fv, mw, x, a;
    logic [127:0]   st_step;

    function automatic logic [31:0] rotr(input logic [31:0] v, input logic [4:0] sh);
        logic [63:0] w;
        w = {v, v} >> sh;
        return w[31:0];
    endfunction

    function automatic logic [31:0] t_const(input logic [5:0] i);
        t_const = '0;
        case (i)
            6'd0:  t_const = 32'hd76aa478;  6'd1:  t_const = 32'he8c7b756;
            6'd2:  t_const = 32'h242070db;  6'd3:  t_const = 32'hc1bdceee;
            6'd4:  t_const = 32'hf57c0faf;  6'd5:  t_const = 32'h4787c62a;
            6'd6:  t_const = 32'ha8304613;  6'd7:  t_const = 32'hfd469501;
            6'd8:  t_const = 32'h698098d8;  6'd9:  t_const = 32'h8b44f7af;
            6'd10: t_const = 32'hffff5bb1;  6'd11: t_const = 32'h895cd7be;
            6'd12: t_const = 32'h6b901122;  6'd13: t_const = 32'hfd987193;
            6'd14: t_const = 32'ha679438e;  6'd15: t_const = 32'h49b40821;
            6'd16: t_const = 32'hf61e2562;  6'd17: t_const = 32'hc040b340;
            6'd18: t_const = 32'h265e5a51;  6'd19: t_const = 32'he9b6c7aa;
            6'd20: t_const = 32'hd62f105d;  6'd21: t_const = 32'h02441453;
            6'd22: t_const = 32'hd8a1e681;  6'd23: t_const = 32'he7d3fbc8;
            6'd24: t_const = 32'h21e1cde6;  6'd25: t_const = 32'hc33707d6;
            6'd26: t_const = 32'hf4d50d87;  6'd27: t_const = 32'h455a14ed;
            6'd28: t_const = 32'ha9e3e905;  6'd29: t_const = 32'hfcefa3f8;
            6'd30: t_const = 32'h676f02d9;  6'd31: t_const = 32'h8d2a4c8a;
            6'd32: t_const = 32'hfffa3942;  6'd33: t_const = 32'h8771f681;
            6'd34: t_const = 32'h6d9d6122;  6'd35: t_const = 32'hfde5380c;
            6'd36: t_const = 32'ha4beea44;  6'd37: t_const = 32'h4bdecfa9;
            6'd38: t_const = 32'hf6bb4b60;  6'd39: t_const = 32'hbebfbc70;
            6'd40: t_const = 32'h289b7ec6;  6'd41: t_const = 32'heaa127fa;
            6'd42: t_const = 32'hd4ef3085;  6'd43: t_const = 32'h04881d05;
            6'd44: t_const = 32'hd9d4d039;  6'd45: t_const = 32'he6db99e5;
            6'd46: t_const = 32'h1fa27cf8;  6'd47: t_const = 32'hc4ac5665;
            6'd48: t_const = 32'hf4292244;  6'd49: t_const = 32'h432aff97;
            6'd50: t_const = 32'hab9423a7;  6'd51: t_const = 32'hfc93a039;
            6'd52: t_const = 32'h655b59c3;  6'd53: t_const = 32'h8f0ccc92;
            6'd54: t_const = 32'hffeff47d;  6'd55: t_const = 32'h85845dd1;
            6'd56: t_const = 32'h6fa87e4f;  6'd57: t_const = 32'hfe2ce6e0;
            6'd58: t_const = 32'ha3014314;  6'd59: t_const = 32'h4e0811a1;
            6'd60: t_const = 32'hf7537e82;  6'd61: t_const = 32'hbd3af235;
            6'd62: t_const = 32'h2ad7d2bb;  6'd63: t_const = 32'heb86d391;
            default: t_const = '0;
        endcase
    endfunction

    // Inverse step: the forward op rotated {a,b,c,d} into {d,b',b,c}, so the
    // operands b, c, d sit directly in words 2, 3 and 0 of the current state.
    always_comb begin
        rnd   = cnt[5:4];
        phase = cnt[3:0];
        n0    = st[127:96];
        n1    = st[95:64];
        n2    = st[63:32];
        n3    = st[31:0];
        fv    = '0;
        k     = '0;
        case (rnd)
            2'd0: begin fv = (n2 & n3) | (~n2 & n0);  k = phase;                 end
            2'd1: begin fv = (n2 & n0) | (n3 & ~n0);  k = phase * 4'd5 + 4'd1;  end
            2'd2: begin fv = n2 ^ n3 ^ n0;            k = phase * 4'd3 + 4'd5;  end
            default: begin fv = n3 ^ (n2 | ~n0);      k = phase * 4'd7;         end
        endcase
        s = 5'd0;
        case ({rnd, phase[1:0]})
            4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
            4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
            4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
            4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
        endcase
        mw      = msg_q[{4'd15 - k, 5'd0} +: 32];
        x       = rotr(n1 - n2, s);
        a       = x - fv - mw - t_const(cnt);
        st_step = {a, n2, n3, n0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt == 6'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= 6'h3F;
            st    <= '0;
            msg_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    msg_q <= message;
                    st    <= {digest[127:96] - `SALT_A, digest[95:64] - `SALT_B,
                              digest[63:32]  - `SALT_C, digest[31:0]  - `SALT_D};
                    cnt   <= 6'h3F;
                end
                RUN: begin
                    st  <= st_step;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd0) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign state_out = st;
    assign match     = (st == {`SALT_A, `SALT_B, `SALT_C, `SALT_D});

endmodule

// File: tb/tb_md5_reverse.sv
// Bench for md5_reverse: a textbook forward MD5 model checks every recovered
// state by re-running it forward, plus a cycle-level busy/done schedule model.

module tb_md5_reverse;

    logic         clk, rst, start;
    logic [511:0] message;
    logic [127:0] digest;
    logic         busy, done, match;
    logic [127:0] state_out;

    md5_reverse dut (
        .clk(clk), .rst(rst), .start(start), .message(message), .digest(digest),
        .busy(busy), .done(done), .state_out(state_out), .match(match)
    );

    localparam logic [127:0] SALTS = 128'h67452301_efcdab89_98badcfe_10325476;
    localparam int SH [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    int n_pass, n_total, done_seen;

    int           m_left;
    bit           m_done, m_have, m_lit_ok, m_neg;
    logic [511:0] m_msg;
    logic [127:0] m_dig, m_lit;

    logic [127:0] req_lit;
    bit           req_lit_ok, req_neg;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // T[i] = floor(|sin(i+1)| * 2^32)
    function automatic logic [31:0] t_const(input int i);
        real v;
        v = $sin(real'(i + 1));
        if (v < 0.0) v = -v;
        v = $floor(v * 4294967296.0);
        return 32'(longint'(v));
    endfunction

    function automatic logic [127:0] add4(input logic [127:0] x, input logic [127:0] y);
        return {x[127:96] + y[127:96], x[95:64] + y[95:64], x[63:32] + y[63:32], x[31:0] + y[31:0]};
    endfunction

    function automatic logic [127:0] md5_fwd(input logic [511:0] msg, input logic [127:0] st);
        logic [31:0] a, b, c, d, f, tmp, sum;
        int g, s;
        a = st[127:96]; b = st[95:64]; c = st[63:32]; d = st[31:0];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i;                end
                1: begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16;     end
            endcase
            s   = SH[(i / 16) * 4 + i % 4];
            sum = a + f + t_const(i) + msg[480 - 32 * g +: 32];
            tmp = d; d = c; c = b;
            b   = b + ((sum << s) | (sum >> (32 - s)));
            a   = tmp;
        end
        return {a, b, c, d};
    endfunction

    // Schedule model: a request sampled in idle keeps the block busy for 64 edges.
    initial begin
        m_left = 0; m_done = 0; m_have = 0; m_lit_ok = 0; m_neg = 0;
        m_msg = '0; m_dig = '0; m_lit = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_left = 0; m_done = 0; m_have = 0;
            end else begin
                m_done = 0;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin m_done = 1; m_have = 1; end
                end else if (start) begin
                    m_left = 64; m_have = 0;
                    m_msg = message; m_dig = digest;
                    m_lit = req_lit; m_lit_ok = req_lit_ok; m_neg = req_neg;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", 128'(busy), 128'(0));
                chk("rst_done", 128'(done), 128'(0));
                chk("rst_state", state_out, '0);
                chk("rst_match", 128'(match), 128'(0));
            end else begin
                chk("busy", 128'(busy), 128'(m_left > 0));
                chk("done", 128'(done), 128'(m_done));
                if (done) done_seen++;
                if (m_have) begin
                    chk("reforward", add4(md5_fwd(m_msg, state_out), SALTS), m_dig);
                    chk("match", 128'(match), 128'(m_dig == add4(md5_fwd(m_msg, SALTS), SALTS)));
                    if (m_done && m_lit_ok) chk("state_lit", state_out, m_lit);
                    if (m_done && m_neg) chk("differs_from_salts", 128'(state_out == SALTS), 128'(0));
                end
            end
        end
    end

    task automatic issue(input logic [511:0] msg, input logic [127:0] dig,
                         input logic [127:0] lit, input bit lit_ok, input bit neg);
        message = msg; digest = dig;
        req_lit = lit; req_lit_ok = lit_ok; req_neg = neg;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        message = ~msg; digest = ~dig;
    endtask

    task automatic run_req(input logic [511:0] msg, input logic [127:0] dig,
                           input logic [127:0] lit, input bit lit_ok, input bit neg);
        int edges;
        issue(msg, dig, lit, lit_ok, neg);
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("latency", 128'(edges), 128'(64));
    endtask

    logic [511:0] msg1, rmsg;
    logic [127:0] g, s0;
    int d0, w;

    initial begin
        n_pass = 0; n_total = 0; done_seen = 0;
        rst = 1'b1; start = 1'b0; message = '0; digest = '0;
        req_lit = '0; req_lit_ok = 0; req_neg = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        chk("t_const0", 128'(t_const(0)), 128'(32'hd76aa478));
        chk("t_const10", 128'(t_const(10)), 128'(32'hffff5bb1));
        chk("t_const63", 128'(t_const(63)), 128'(32'heb86d391));
        chk("md5_empty", add4(md5_fwd({32'h00000080, 480'h0}, SALTS), SALTS),
            128'hd98c1dd4_04b2008f_980980e9_7e42f8ec);

        msg1 = {128'h0123456789abcdef_fedcba9876543210, 384'h0};
        g    = add4(md5_fwd(msg1, SALTS), SALTS);
        run_req(msg1, g, SALTS, 1, 0);
        run_req(msg1, g ^ 128'h1, '0, 0, 1);

        // Extra start pulses mid-run must be ignored and must not re-latch inputs.
        d0 = done_seen;
        issue(msg1, g, SALTS, 1, 0);
        for (int e = 1; e <= 64; e++) begin
            if (e == 10 || e == 40) begin
                start = 1'b1;
                message = {16{$urandom}};
                digest = {4{$urandom}};
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("single_done", 128'(done_seen - d0), 128'(1));

        // Reset mid-run.
        issue(msg1, g, SALTS, 1, 0);
        repeat (30) @(negedge clk);
        d0 = done_seen;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (70) @(negedge clk);
        chk("no_done_after_abort", 128'(done_seen - d0), 128'(0));
        run_req(msg1, g, SALTS, 1, 0);

        for (int i = 0; i < 1000; i++) begin
            rmsg = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            s0   = {$urandom, $urandom, $urandom, $urandom};
            run_req(rmsg, add4(md5_fwd(rmsg, s0), SALTS), s0, 1, 0);
        end

        // start held high: back-to-back runs every 65 cycles.
        repeat (2) @(negedge clk);
        d0 = done_seen;
        message = msg1; digest = g;
        req_lit = SALTS; req_lit_ok = 1; req_neg = 0;
        start = 1'b1;
        repeat (200) @(negedge clk);
        chk("held_start_dones", 128'(done_seen - d0), 128'(3));
        start = 1'b0;
        w = 0;
        while (!done && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("held_start_last_done", 128'(done), 128'(1));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
